// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int BURST_MAX_DEF = 4;
    localparam int STALL_W       = 16;

    // Index width that stays legal for a single requester too.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester streams plus FIFO write side; master = arbiter, slave = environment.
interface fifo_wr_arb_if #(
    parameter int NREQ = fifo_arb_pkg::NREQ_DEF,
    parameter int DW   = fifo_arb_pkg::DW_DEF
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_w_en;
    logic [DW-1:0]      fifo_data_in;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [IW-1:0]   win_o,
    output logic            any_o
);

    logic [IW-1:0] idx;

    // Walk the rotation backwards so the closest requester to last+1 overwrites last.
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last_i) + k) % NREQ);
            if (req_i[idx]) win_o = idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready streams.
// Optional stall statistics counter enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int DW        = DW_DEF,
    parameter  int BURST_MAX = BURST_MAX_DEF,
    localparam int IW        = idx_w(NREQ),
    localparam int BCW       = $clog2(BURST_MAX) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_wr_arb_if.master bus,
    output logic [IW-1:0] grant_id,
    output logic          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  grant_id_q, grant_id_d;
    logic [IW-1:0]  last_grant_q, last_grant_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IW-1:0]  winner;
    logic           any_req;
    logic           gvalid;
    logic [DW-1:0]  gdata;
    logic           xfer;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i  (bus.req_valid),
        .last_i (last_grant_q),
        .win_o  (winner),
        .any_o  (any_req)
    );

    assign gvalid = bus.req_valid[grant_id_q];
    assign gdata  = bus.req_data[grant_id_q*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IW'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        bus.req_ready = '0;
        xfer          = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                bus.req_ready[grant_id_q] = !bus.fifo_full;
                xfer = gvalid && !bus.fifo_full;
                // A dropped valid forfeits the grant; a full FIFO just stalls.
                if (!gvalid) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (beat_cnt_q == BCW'(BURST_MAX - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_w_en    = xfer;
    assign bus.fifo_data_in = xfer ? gdata : '0;
    assign grant_id         = grant_id_q;
    assign busy             = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == BURST && gvalid && bus.fifo_full && stall_q != '1) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed scoreboard bench for fifo_wr_arb: expected FIFO writes queued at load, checked on write.
module tb_fifo_wr_arb;
    import fifo_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] grant_id;
    logic busy;
`ifdef FIFO_ARB_STATS_EN
    logic [STALL_W-1:0] stall_cnt;
`endif

    fifo_wr_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .BURST_MAX(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [NREQ-1:0] fire_q = '0;
    logic [NREQ-1:0] en = '1;
    logic full_v = 1'b0;
    logic [7:0] src_q [NREQ][$];
    exp_t exp_q [$];
    int wcyc_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop on every FIFO write, plus per-cycle safety checks.
    always @(negedge clk) begin
        cyc++;
        fire_q = bus.req_valid & bus.req_ready;
        if (bus.fifo_full) chk("write_while_full", 64'(bus.fifo_w_en), 64'd0);
        if (bus.fifo_w_en) begin
            wcyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(bus.fifo_data_in), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_data", 64'(bus.fifo_data_in), 64'(e.data));
                chk("wr_id", 64'(grant_id), 64'(e.id));
            end
        end
    end

    task automatic drive();
        logic [NREQ-1:0]    v;
        logic [NREQ*DW-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = en[i] && (src_q[i].size() > 0);
            if (src_q[i].size() > 0) d[i*DW +: DW] = src_q[i][0];
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.fifo_full = full_v;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (fire_q[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic load(input int id, input logic [7:0] d, input bit expect_wr);
        exp_t e;
        src_q[id].push_back(d);
        if (expect_wr) begin
            e.id = id;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            cycle();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        en = '1;
        full_v = 1'b0;
        drive();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    function automatic logic [63:0] wmask(input int base);
        logic [63:0] m;
        m = '0;
        foreach (wcyc_q[i]) begin
            int o;
            o = wcyc_q[i] - base;
            if (o >= 0 && o < 64) m[o] = 1'b1;
            else m[63] = 1'b1;
        end
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [63:0] m2;

        // Reset state, sampled while rst_n is low and just after release.
        drive();
        neg();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_wen", 64'(bus.fifo_w_en), 64'd0);
        chk("rst_data", 64'(bus.fifo_data_in), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        neg();
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Single requester 1, six beats: bursts of 4 then 2 with one bubble.
        wcyc_q.delete();
        for (int k = 0; k < 6; k++) load(1, 8'(8'h10 + k), 1'b1);
        cycle();
        base = cyc + 1;
        drain("t1_drain", 40);
        chk("t1_timing", wmask(base), 64'hDE);

        // All four valid continuously: order 0,1,2,3,0,1,2,3, bubble between bursts.
        do_reset();
        wcyc_q.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                for (int k = 0; k < 4; k++) load(i, 8'((i << 4) | (r * 4 + k)), 1'b1);
        drive();
        base = cyc + 1;
        drain("t2_drain", 100);
        m2 = '0;
        for (int b = 0; b < 8; b++) m2 |= 64'h1E << (5 * b);
        chk("t2_timing", wmask(base), m2);

        // Requester 2 stalled by fifo_full for three cycles mid-burst.
        wcyc_q.delete();
        for (int k = 0; k < 4; k++) load(2, 8'(8'h30 + k), 1'b1);
        drive();
        base = cyc + 1;
        cycle();
        cycle();
        cycle();
        full_v = 1'b1;
        drive();
        neg();
        chk("t3_ready2", 64'(bus.req_ready[2]), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        cycle();
        cycle();
        cycle();
        full_v = 1'b0;
        drive();
        drain("t3_drain", 40);
        chk("t3_timing", wmask(base), 64'hC6);
`ifdef FIFO_ARB_STATS_EN
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd3);
`endif

        // Requester 0 drops valid after two beats while 3 waits.
        do_reset();
        wcyc_q.delete();
        load(0, 8'h40, 1'b1);
        load(0, 8'h41, 1'b1);
        for (int k = 0; k < 4; k++) load(3, 8'(8'h70 + k), 1'b1);
        drive();
        base = cyc + 1;
        drain("t4_drain", 40);
        chk("t4_timing", wmask(base), 64'h1E6);

        // Reset mid-burst after one beat; afterwards arbitration restarts at 0.
        wcyc_q.delete();
        load(1, 8'h50, 1'b1);
        for (int k = 1; k < 4; k++) load(1, 8'(8'h50 + k), 1'b0);
        drive();
        cycle();
        cycle();
        rst_n = 1'b0;
        neg();
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_wen", 64'(bus.fifo_w_en), 64'd0);
        chk("t5_ready", 64'(bus.req_ready), 64'd0);
        chk("t5_grant", 64'(grant_id), 64'd0);
        chk("t5_data", 64'(bus.fifo_data_in), 64'd0);
        chk("t5_one_write", 64'(wcyc_q.size()), 64'd1);
        src_q[1].delete();
        cycle();
        rst_n = 1'b1;
        cycle();
        wcyc_q.delete();
        load(2, 8'h62, 1'b0);
        load(0, 8'h60, 1'b1);
        exp_q.push_back('{id: 2, data: 8'h62});
        drive();
        base = cyc + 1;
        drain("t5_drain", 40);
        chk("t5_timing", wmask(base), 64'h12);

        // fifo_full high at grant: no writes, BURST held until valid drops.
        wcyc_q.delete();
        full_v = 1'b1;
        load(3, 8'h80, 1'b0);
        load(3, 8'h81, 1'b0);
        drive();
        cycle();
        neg();
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_grant", 64'(grant_id), 64'd3);
        chk("t6_ready", 64'(bus.req_ready), 64'd0);
        repeat (4) cycle();
        neg();
        chk("t6_busy_held", 64'(busy), 64'd1);
        en[3] = 1'b0;
        drive();
        cycle();
        neg();
        chk("t6_busy_drop", 64'(busy), 64'd0);
        chk("t6_no_writes", 64'(wcyc_q.size()), 64'd0);
        src_q[3].delete();
        en = '1;
        full_v = 1'b0;
        drive();
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
